fetch_ctrl: RTL and testbench

//  Sequencer for the dual-slot fetch buffer: owns the fetch PC and issues one aligned
//  64-bit I-cache request at a time, then forwards the returned pair into the buffer.

---
 rtl/fetch_ctrl_if.sv | 33 +++
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: back-end control, I-cache request/response and fetch-buffer write port.
interface fetch_ctrl_if #(
   parameter int unsigned FB_DEPTH = 8
);
   localparam int unsigned FREE_W = $clog2(FB_DEPTH) + 1;

   logic              fetch_en;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              ic_req;
   logic [31:0]       ic_addr;
   logic              ic_ready;
   logic              ic_rvalid;
   logic [63:0]       ic_rdata;
   logic [FREE_W-1:0] fb_free;
   logic [31:0]       fb_pc;
   logic [63:0]       fb_irin;
   logic              fb_if0;
   logic              fb_if1;
   logic              fb_flush;

   // Sequencer side
   modport master (
      input  fetch_en, redirect, redirect_pc, ic_ready, ic_rvalid, ic_rdata, fb_free,
      output ic_req, ic_addr, fb_pc, fb_irin, fb_if0, fb_if1, fb_flush
   );

   // Environment side (back-end, I-cache, fetch buffer)
   modport slave (
      output fetch_en, redirect, redirect_pc, ic_ready, ic_rvalid, ic_rdata, fb_free,
      input  ic_req, ic_addr, fb_pc, fb_irin, fb_if0, fb_if1, fb_flush
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one aligned 64-bit I-cache request at a
// time, forwards returned pairs into the fetch buffer and handles back-end redirects.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h1c000000,
   parameter int unsigned FB_DEPTH = 8
) (
   input  logic         clk,
   input  logic         rstn,
   fetch_ctrl_if.master bus
);

   localparam int unsigned FREE_W = $clog2(FB_DEPTH) + 1;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] fb_pc_q, fb_pc_d;
   logic [63:0] fb_irin_q, fb_irin_d;
   logic        fb_if0_q, fb_if0_d;
   logic        fb_if1_q, fb_if1_d;
   logic        fb_flush_q, fb_flush_d;
   logic        ic_req_c;
   logic [31:0] pair_pc_c;
   logic        space_ok_c;

   // Low address bits never matter: requests are 8-byte aligned and slot choice uses bit 2 only
   logic unused_bits;
   assign unused_bits = ^{bus.redirect_pc[1:0], pc_q[2:0], req_pc_q[1:0]};

   assign pair_pc_c  = {req_pc_q[31:3], 3'b000};
   assign space_ok_c = (bus.fb_free >= FREE_W'(2));

   // Next-state, request and fetch-buffer write decode; redirect overrides everything
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      fb_pc_d    = fb_pc_q;
      fb_irin_d  = fb_irin_q;
      fb_if0_d   = 1'b0;
      fb_if1_d   = 1'b0;
      fb_flush_d = 1'b0;
      ic_req_c   = 1'b0;

      case (state_q)
         S_REQ: begin
            // A write in flight hides one cycle of stale fb_free, so hold off while writing
            ic_req_c = bus.fetch_en & ~bus.redirect & space_ok_c & ~(fb_if0_q | fb_if1_q);
            if (ic_req_c && bus.ic_ready) begin
               req_pc_d = pc_q;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.redirect) begin
               state_d = bus.ic_rvalid ? S_REQ : S_DROP;
            end else if (bus.ic_rvalid) begin
               fb_irin_d = bus.ic_rdata;
               fb_pc_d   = pair_pc_c;
               fb_if1_d  = 1'b1;
               fb_if0_d  = ~req_pc_q[2];
               pc_d      = pair_pc_c + 32'd8;
               state_d   = S_REQ;
            end
         end
         S_DROP: begin
            // Stale response is swallowed; a redirect alone keeps us waiting for it
            if (bus.ic_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase

      if (bus.redirect) begin
         pc_d       = {bus.redirect_pc[31:2], 2'b00};
         fb_flush_d = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         fb_pc_q    <= 32'd0;
         fb_irin_q  <= 64'd0;
         fb_if0_q   <= 1'b0;
         fb_if1_q   <= 1'b0;
         fb_flush_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         fb_pc_q    <= fb_pc_d;
         fb_irin_q  <= fb_irin_d;
         fb_if0_q   <= fb_if0_d;
         fb_if1_q   <= fb_if1_d;
         fb_flush_q <= fb_flush_d;
      end
   end

   assign bus.ic_req   = ic_req_c;
   assign bus.ic_addr  = {pc_q[31:3], 3'b000};
   assign bus.fb_pc    = fb_pc_q;
   assign bus.fb_irin  = fb_irin_q;
   assign bus.fb_if0   = fb_if0_q;
   assign bus.fb_if1   = fb_if1_q;
   assign bus.fb_flush = fb_flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected requests, pairs and flushes;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_fetch_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] data;
      logic        if0;
      logic        if1;
   } fb_exp_t;

   logic clk = 1'b0;
   logic rstn;

   int checks = 0;
   int errors = 0;

   logic [31:0] addr_q[$];
   fb_exp_t     fb_q[$];
   int          flush_pend = 0;
   fb_exp_t     mon_e;

   fetch_ctrl_if #(.FB_DEPTH(8)) bus ();

   fetch_ctrl #(
      .RESET_PC (32'h1c000000),
      .FB_DEPTH (8)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s unexpected output actual=%h required=none", name, act);
   endtask

   // Monitor: compare every accepted request, buffer write and flush against the scoreboard
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.ic_req && bus.ic_ready) begin
            if (addr_q.size() == 0) unexp("ic_addr", 64'(bus.ic_addr));
            else chk("ic_addr", 64'(bus.ic_addr), 64'(addr_q.pop_front()));
         end
         if (bus.fb_if0 || bus.fb_if1) begin
            if (fb_q.size() == 0) unexp("fb_write", bus.fb_irin);
            else begin
               mon_e = fb_q.pop_front();
               chk("fb_pc", 64'(bus.fb_pc), 64'(mon_e.pc));
               chk("fb_irin", bus.fb_irin, mon_e.data);
               chk("fb_if0", 64'(bus.fb_if0), 64'(mon_e.if0));
               chk("fb_if1", 64'(bus.fb_if1), 64'(mon_e.if1));
            end
         end
         if (bus.fb_flush) begin
            if (flush_pend == 0) unexp("fb_flush", 64'(bus.fb_flush));
            else begin
               flush_pend--;
               chk("flush_no_write", 64'(bus.fb_if0 | bus.fb_if1), 64'd0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_pair(input logic [31:0] pc, input logic [63:0] d,
                           input logic if0, input logic if1);
      fb_exp_t e;
      e.pc = pc; e.data = d; e.if0 = if0; e.if1 = if1;
      fb_q.push_back(e);
   endtask

   // Raise ic_ready until the DUT's request is accepted (bounded)
   task automatic wait_accept();
      bit ok = 1'b0;
      bus.ic_ready = 1'b1;
      #1;
      for (int i = 0; i < 40; i++) begin
         if (bus.ic_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_request required=request");
      end
      bus.ic_ready = 1'b0;
   endtask

   // Return a response dly cycles after acceptance
   task automatic respond(input int dly, input logic [63:0] d);
      repeat (dly - 1) tick();
      bus.ic_rvalid = 1'b1;
      bus.ic_rdata  = d;
      tick();
      bus.ic_rvalid = 1'b0;
      bus.ic_rdata  = 64'd0;
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      bus.redirect    = 1'b1;
      bus.redirect_pc = tgt;
      flush_pend++;
      tick();
      bus.redirect    = 1'b0;
   endtask

   initial begin
      rstn            = 1'b0;
      bus.fetch_en    = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.ic_ready    = 1'b0;
      bus.ic_rvalid   = 1'b0;
      bus.ic_rdata    = 64'd0;
      bus.fb_free     = 4'd8;
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      // Reset state
      chk("rst_ic_addr", 64'(bus.ic_addr), 64'h1c000000);
      chk("rst_ic_req", 64'(bus.ic_req), 64'd0);
      chk("rst_fb_if", 64'({bus.fb_if0, bus.fb_if1, bus.fb_flush}), 64'd0);
      chk("rst_fb_pc", 64'(bus.fb_pc), 64'd0);
      chk("rst_fb_irin", bus.fb_irin, 64'd0);

      // Sequential aligned fetch
      bus.fetch_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr_q.push_back(32'h1c000000 + 32'(k * 8));
         exp_pair(32'h1c000000 + 32'(k * 8), 64'hA0000000_00000000 | 64'(k), 1'b1, 1'b1);
         wait_accept();
         respond(2, 64'hA0000000_00000000 | 64'(k));
      end

      // Redirect in REQ to an unaligned target
      do_redirect(32'h11111114);
      addr_q.push_back(32'h11111110);
      exp_pair(32'h11111110, 64'hB1B1B1B1_C2C2C2C2, 1'b0, 1'b1);
      wait_accept();
      respond(2, 64'hB1B1B1B1_C2C2C2C2);
      addr_q.push_back(32'h11111118);
      exp_pair(32'h11111118, 64'h12345678_9ABCDEF0, 1'b1, 1'b1);
      wait_accept();
      respond(3, 64'h12345678_9ABCDEF0);

      // Redirect while WAIT: late response is stale
      addr_q.push_back(32'h11111120);
      wait_accept();
      do_redirect(32'h20000000);
      respond(3, 64'hDEADBEEF_DEADBEEF);
      addr_q.push_back(32'h20000000);
      exp_pair(32'h20000000, 64'h0BADF00D_CAFEF00D, 1'b1, 1'b1);
      wait_accept();
      respond(2, 64'h0BADF00D_CAFEF00D);

      // Redirect coincident with rvalid
      addr_q.push_back(32'h20000008);
      wait_accept();
      tick();
      bus.ic_rvalid   = 1'b1;
      bus.ic_rdata    = 64'h55555555_55555555;
      do_redirect(32'h30000004);
      bus.ic_rvalid   = 1'b0;
      bus.ic_rdata    = 64'd0;
      addr_q.push_back(32'h30000000);
      exp_pair(32'h30000000, 64'h66666666_77777777, 1'b0, 1'b1);
      wait_accept();
      respond(2, 64'h66666666_77777777);

      // Free-slot throttle
      bus.fb_free  = 4'd1;
      addr_q.push_back(32'h30000008);
      exp_pair(32'h30000008, 64'h88888888_99999999, 1'b1, 1'b1);
      bus.ic_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("throttle_ic_req", 64'(bus.ic_req), 64'd0);
         tick();
      end
      bus.fb_free = 4'd4;
      #1;
      chk("unthrottle_ic_req", 64'(bus.ic_req), 64'd1);
      tick();
      bus.ic_ready = 1'b0;
      respond(2, 64'h88888888_99999999);
      bus.fb_free = 4'd8;

      // Address wrap
      do_redirect(32'hFFFFFFF8);
      addr_q.push_back(32'hFFFFFFF8);
      exp_pair(32'hFFFFFFF8, 64'hFEEDFACE_01234567, 1'b1, 1'b1);
      wait_accept();
      respond(2, 64'hFEEDFACE_01234567);
      addr_q.push_back(32'h00000000);
      wait_accept();

      // Async reset mid-WAIT
      tick();
      #2;
      rstn         = 1'b0;
      bus.fetch_en = 1'b0;
      #1;
      chk("arst_ic_req", 64'(bus.ic_req), 64'd0);
      chk("arst_ic_addr", 64'(bus.ic_addr), 64'h1c000000);
      chk("arst_fb_if", 64'({bus.fb_if0, bus.fb_if1, bus.fb_flush}), 64'd0);
      chk("arst_fb_pc", 64'(bus.fb_pc), 64'd0);
      chk("arst_fb_irin", bus.fb_irin, 64'd0);
      tick();
      tick();
      rstn = 1'b1;
      tick();
      respond(1, 64'h13572468_13572468);
      tick();
      chk("late_rvalid_pc", 64'(bus.ic_addr), 64'h1c000000);

      // Scoreboard drained
      chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
      chk("fb_q_empty", 64'(fb_q.size()), 64'd0);
      chk("flush_pend_zero", 64'(flush_pend), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
